// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage:
// reset PC default, NOP encoding and fetch FSM states.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem handshake, one-entry output buffer.
// Ports: clk, rst (async low), stall, branch_taken/target, imem_*, inst_out/pc_out/inst_valid.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid
);

  localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;

  if_state_e   state;
  logic [31:0] pc;
  logic [31:0] tgt;
  logic [31:0] bt_al;
  logic [31:0] pc_inc;
  logic        capture;

  assign bt_al     = branch_target & ~32'h3;
  assign pc_inc    = pc + 32'd4;
  assign imem_addr = pc;

  always_comb begin
    imem_req = 1'b0;
    unique case (state)
      S_IDLE:  imem_req = 1'b0;
      S_FETCH: imem_req = !inst_valid || !stall;
      S_DROP:  imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // A redirect in the ack cycle discards the returned word.
  assign capture = (state == S_FETCH) && imem_req &&
                   imem_ack && !branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc         <= PC_INIT;
      tgt        <= PC_INIT;
      inst_out   <= NOP_INST;
      pc_out     <= 32'h0;
      inst_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state <= S_FETCH;
          if (branch_taken) pc <= bt_al;
        end
        S_FETCH: begin
          if (branch_taken) begin
            // Outstanding request must finish at the old address.
            if (imem_req && !imem_ack) begin
              tgt   <= bt_al;
              state <= S_DROP;
            end else begin
              pc <= bt_al;
            end
          end else if (capture) begin
            inst_out <= imem_rdata;
            pc_out   <= pc;
            pc       <= pc_inc;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            pc    <= branch_taken ? bt_al : tgt;
            state <= S_FETCH;
          end else if (branch_taken) begin
            tgt <= bt_al;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (branch_taken)  inst_valid <= 1'b0;
      else if (capture)  inst_valid <= 1'b1;
      else if (!stall)   inst_valid <= 1'b0;
    end
  end

endmodule
